// File: rtl/pasc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pasc_pkg
// Purpose  : Shared sizes, core instruction encoding and round-robin helper
//            for the PASC multicore.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package pasc_pkg;
   localparam int NUM_CORES       = 8;
   localparam int DATA_WIDTH      = 16;
   localparam int LOCAL_MEM_WORDS = 4096;
   localparam int MEM_ADDR_W      = $clog2(LOCAL_MEM_WORDS);
   localparam int CORE_ID_W       = 3;
   localparam logic [DATA_WIDTH-1:0] IO_OUTPUT_ADDR = 16'hffff;

   typedef logic [DATA_WIDTH-1:0] word_t;

   // Instruction word: [15:12] opcode, [11:0] immediate.
   // LDI and ST take a second word (literal / store address) at pc+1.
   typedef enum logic [3:0] {
      OP_HALT = 4'h0,   // stay on this pc forever
      OP_NOP  = 4'h1,
      OP_LDI  = 4'h2,   // acc <= mem[pc+1]
      OP_ST   = 4'h3,   // mem[mem[pc+1]] <= acc, or output port if IO_OUTPUT_ADDR
      OP_LDID = 4'h4,   // acc <= CORE_ID << imm[3:0]
      OP_ADDI = 4'h5,   // acc <= acc + imm
      OP_OUTI = 4'h6    // output port <= zero-extended imm
   } opcode_e;

   // Core index 'offset' positions after 'base', wrapping around the cluster.
   function automatic logic [CORE_ID_W-1:0] rr_index(input logic [CORE_ID_W-1:0] base,
                                                      input int unsigned offset);
      rr_index = base + offset[CORE_ID_W-1:0];
   endfunction
endpackage
`default_nettype wire

// File: rtl/pasc_cluster.sv
`default_nettype none
// ============================================================================
// Module   : pasc_cluster
// Purpose  : Eight-core cluster; instances core0..core7 with hardwired ids.
// Ports    : i_clk, i_rst; per-core output-port bus o_io_write_en[N],
//            o_io_write_data[N], i_io_ready[N].
// Revision : 1.0  initial release
// ============================================================================
module pasc_cluster
   import pasc_pkg::*;
(
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [NUM_CORES-1:0]                 i_io_ready,
   output logic [NUM_CORES-1:0]                 o_io_write_en,
   output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] o_io_write_data
);
   // Explicit instances keep the hierarchical names core0..core7 stable.
   pasc_core #(.CORE_ID(3'd0)) core0 (.i_clk(i_clk), .i_rst(i_rst), .i_io_ready(i_io_ready[0]),
      .o_io_write_en(o_io_write_en[0]), .o_io_write_data(o_io_write_data[0]));
   pasc_core #(.CORE_ID(3'd1)) core1 (.i_clk(i_clk), .i_rst(i_rst), .i_io_ready(i_io_ready[1]),
      .o_io_write_en(o_io_write_en[1]), .o_io_write_data(o_io_write_data[1]));
   pasc_core #(.CORE_ID(3'd2)) core2 (.i_clk(i_clk), .i_rst(i_rst), .i_io_ready(i_io_ready[2]),
      .o_io_write_en(o_io_write_en[2]), .o_io_write_data(o_io_write_data[2]));
   pasc_core #(.CORE_ID(3'd3)) core3 (.i_clk(i_clk), .i_rst(i_rst), .i_io_ready(i_io_ready[3]),
      .o_io_write_en(o_io_write_en[3]), .o_io_write_data(o_io_write_data[3]));
   pasc_core #(.CORE_ID(3'd4)) core4 (.i_clk(i_clk), .i_rst(i_rst), .i_io_ready(i_io_ready[4]),
      .o_io_write_en(o_io_write_en[4]), .o_io_write_data(o_io_write_data[4]));
   pasc_core #(.CORE_ID(3'd5)) core5 (.i_clk(i_clk), .i_rst(i_rst), .i_io_ready(i_io_ready[5]),
      .o_io_write_en(o_io_write_en[5]), .o_io_write_data(o_io_write_data[5]));
   pasc_core #(.CORE_ID(3'd6)) core6 (.i_clk(i_clk), .i_rst(i_rst), .i_io_ready(i_io_ready[6]),
      .o_io_write_en(o_io_write_en[6]), .o_io_write_data(o_io_write_data[6]));
   pasc_core #(.CORE_ID(3'd7)) core7 (.i_clk(i_clk), .i_rst(i_rst), .i_io_ready(i_io_ready[7]),
      .o_io_write_en(o_io_write_en[7]), .o_io_write_data(o_io_write_data[7]));
endmodule
`default_nettype wire

// File: rtl/pasc_core.sv
`default_nettype none
// ============================================================================
// Module   : pasc_core
// Purpose  : Single-cycle accumulator core. Stores to IO_OUTPUT_ADDR (and
//            OUTI) drive the output-port write request; the core stalls on the
//            request until i_io_ready is seen.
// Ports    : i_clk, i_rst (async, active-high); i_io_ready; o_io_write_en,
//            o_io_write_data.
// Revision : 1.0  initial release
// ============================================================================
module pasc_core
   import pasc_pkg::*;
#(
   parameter logic [CORE_ID_W-1:0] CORE_ID = '0
)(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_io_ready,
   output logic  o_io_write_en,
   output word_t o_io_write_data
);
   logic [MEM_ADDR_W-1:0] r_pc;
   word_t                 r_acc;
   logic [MEM_ADDR_W-1:0] w_pc_next;
   word_t                 w_instr;
   word_t                 w_operand;
   opcode_e               w_op;
   logic [11:0]           w_imm;
   logic                  w_mem_we;

   pasc_local_memory local_memory (
      .i_clk     (i_clk),
      .i_raddr_a (r_pc),
      .i_raddr_b (r_pc + MEM_ADDR_W'(1)),
      .i_we      (w_mem_we),
      .i_waddr   (w_operand[MEM_ADDR_W-1:0]),
      .i_wdata   (r_acc),
      .o_rdata_a (w_instr),
      .o_rdata_b (w_operand)
   );

   assign w_op  = opcode_e'(w_instr[15:12]);
   assign w_imm = w_instr[11:0];

   always_comb begin
      o_io_write_en   = 1'b0;
      o_io_write_data = r_acc;
      w_mem_we        = 1'b0;
      w_pc_next       = r_pc + MEM_ADDR_W'(1);
      case (w_op)
         OP_HALT: w_pc_next = r_pc;
         OP_LDI:  w_pc_next = r_pc + MEM_ADDR_W'(2);
         OP_ST: begin
            w_pc_next = r_pc + MEM_ADDR_W'(2);
            if (w_operand == IO_OUTPUT_ADDR) o_io_write_en = 1'b1;
            else                             w_mem_we      = 1'b1;
         end
         OP_OUTI: begin
            o_io_write_en   = 1'b1;
            o_io_write_data = {4'h0, w_imm};
         end
         default: ;
      endcase
      // Refused output write: hold pc so the same request is presented again.
      if (o_io_write_en && !i_io_ready) w_pc_next = r_pc;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc  <= '0;
         r_acc <= '0;
      end else begin
         r_pc <= w_pc_next;
         case (w_op)
            OP_LDI:  r_acc <= w_operand;
            OP_LDID: r_acc <= {{(DATA_WIDTH-CORE_ID_W){1'b0}}, CORE_ID} << w_imm[3:0];
            OP_ADDI: r_acc <= r_acc + {4'h0, w_imm};
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/pasc_local_memory.sv
`default_nettype none
// ============================================================================
// Module   : pasc_local_memory
// Purpose  : Private core memory; two asynchronous read ports (instruction and
//            operand word) and one synchronous write port. Not reset.
// Ports    : i_clk; i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b read ports;
//            i_we/i_waddr/i_wdata write port.
// Revision : 1.0  initial release
// ============================================================================
module pasc_local_memory
   import pasc_pkg::*;
(
   input  logic                  i_clk,
   input  logic [MEM_ADDR_W-1:0] i_raddr_a,
   input  logic [MEM_ADDR_W-1:0] i_raddr_b,
   input  logic                  i_we,
   input  logic [MEM_ADDR_W-1:0] i_waddr,
   input  word_t                 i_wdata,
   output word_t                 o_rdata_a,
   output word_t                 o_rdata_b
);
   // Array name is fixed so program images can be preloaded hierarchically.
   word_t data [LOCAL_MEM_WORDS];

   assign o_rdata_a = data[i_raddr_a];
   assign o_rdata_b = data[i_raddr_b];

   always_ff @(posedge i_clk) begin
      if (i_we) data[i_waddr] <= i_wdata;
   end
endmodule
`default_nettype wire

// File: rtl/pasc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pasc_output_arbiter
// Purpose  : Per-core one-entry holding registers, round-robin grant (one per
//            cycle) and the registered output port.
// Ports    : i_clk, i_rst (async, active-high); i_write_en[N],
//            i_write_data[N], o_ready[N]; o_output_val, o_output_enable.
// Revision : 1.0  initial release
// ============================================================================
module pasc_output_arbiter
   import pasc_pkg::*;
(
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [NUM_CORES-1:0]                 i_write_en,
   input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] i_write_data,
   output logic [NUM_CORES-1:0]                 o_ready,
   output word_t                                o_output_val,
   output logic                                 o_output_enable
);
   logic [NUM_CORES-1:0]                 r_valid;
   logic [NUM_CORES-1:0][DATA_WIDTH-1:0] r_data;
   logic [CORE_ID_W-1:0]                 r_ptr;     // first core searched this cycle
   logic                                 w_any;
   logic [CORE_ID_W-1:0]                 w_gidx;
   logic [NUM_CORES-1:0]                 w_grant;

   // Scan from the farthest offset down so the nearest valid core wins.
   always_comb begin
      w_any  = 1'b0;
      w_gidx = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (r_valid[rr_index(r_ptr, unsigned'(k))]) begin
            w_any  = 1'b1;
            w_gidx = rr_index(r_ptr, unsigned'(k));
         end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         w_grant[i] = w_any && (w_gidx == CORE_ID_W'(i));
      end
   end

   // A register being drained this cycle can take a new word at the same edge.
   assign o_ready = ~r_valid | w_grant;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid         <= '0;
         r_data          <= '0;
         r_ptr           <= '0;
         o_output_val    <= '0;
         o_output_enable <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (i_write_en[i] && o_ready[i]) begin
               r_valid[i] <= 1'b1;
               r_data[i]  <= i_write_data[i];
            end else if (w_grant[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
         o_output_enable <= w_any;
         if (w_any) begin
            o_output_val <= r_data[w_gidx];
            r_ptr        <= w_gidx + CORE_ID_W'(1);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/pasc_top.sv
`default_nettype none
// ============================================================================
// Module   : pasc_top
// Purpose  : PASC chip top: 8-core cluster merged into one output stream by
//            the round-robin output arbiter.
// Ports    : clk; reset (async, active-high); output_val[15:0];
//            output_enable (one-cycle pulse per emitted word).
// Revision : 1.0  initial release
// ============================================================================
module pasc_top
   import pasc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] output_val,
   output logic                  output_enable
);
   logic [NUM_CORES-1:0]                 w_io_write_en;
   logic [NUM_CORES-1:0]                 w_io_ready;
   logic [NUM_CORES-1:0][DATA_WIDTH-1:0] w_io_write_data;

   pasc_cluster cluster (
      .i_clk           (clk),
      .i_rst           (reset),
      .i_io_ready      (w_io_ready),
      .o_io_write_en   (w_io_write_en),
      .o_io_write_data (w_io_write_data)
   );

   pasc_output_arbiter arbiter (
      .i_clk           (clk),
      .i_rst           (reset),
      .i_write_en      (w_io_write_en),
      .i_write_data    (w_io_write_data),
      .o_ready         (w_io_ready),
      .o_output_val    (output_val),
      .o_output_enable (output_enable)
   );
endmodule
`default_nettype wire

// File: tb/tb_pasc_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_pasc_top
// Purpose  : Self-checking bench for pasc_top. Programs are written straight
//            into each core's local memory while reset is held; a monitor
//            records every output pulse and a per-core expected-word model
//            checks order, completeness and uniqueness.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pasc_top;
   localparam logic [3:0] OP_HALT = 4'h0, OP_NOP = 4'h1, OP_LDI = 4'h2, OP_ST = 4'h3,
                          OP_LDID = 4'h4, OP_ADDI = 4'h5, OP_OUTI = 4'h6;
   localparam logic [15:0] IO = 16'hffff;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] output_val;
   logic        output_enable;

   pasc_top dut (.clk(clk), .reset(reset), .output_val(output_val), .output_enable(output_enable));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] obs_val[$];
   int          obs_cyc[$];
   always @(negedge clk) begin
      if (output_enable === 1'b1) begin
         obs_val.push_back(output_val);
         obs_cyc.push_back(cyc);
      end
   end

   int n_checks = 0, n_pass = 0, n_fail = 0;
   int rel = 0;
   logic [15:0] prog [8][64];
   logic [15:0] exp_w [8][48];
   int          exp_n [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] imm);
      return {op, imm};
   endfunction

   task automatic put(input int c, input int a, input logic [15:0] w);
      logic [11:0] ad;
      ad = a[11:0];
      case (c)
         0: dut.cluster.core0.local_memory.data[ad] = w;
         1: dut.cluster.core1.local_memory.data[ad] = w;
         2: dut.cluster.core2.local_memory.data[ad] = w;
         3: dut.cluster.core3.local_memory.data[ad] = w;
         4: dut.cluster.core4.local_memory.data[ad] = w;
         5: dut.cluster.core5.local_memory.data[ad] = w;
         6: dut.cluster.core6.local_memory.data[ad] = w;
         default: dut.cluster.core7.local_memory.data[ad] = w;
      endcase
   endtask

   task automatic clear_prog();
      for (int c = 0; c < 8; c++) begin
         exp_n[c] = 0;
         for (int a = 0; a < 64; a++) prog[c][a] = 16'h0000;
      end
   endtask

   task automatic load_prog();
      for (int c = 0; c < 8; c++)
         for (int a = 0; a < 64; a++) put(c, a, prog[c][a]);
   endtask

   // Reset the chip, load the current images, release on a falling edge.
   task automatic start();
      @(negedge clk);
      reset = 1'b1;
      load_prog();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rel = cyc;
      obs_val.delete();
      obs_cyc.delete();
   endtask

   task automatic run(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic wait_pulses(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (obs_val.size() < n && k < budget) begin @(negedge clk); #1; k++; end
      if (obs_val.size() < n) check(tag, obs_val.size(), n);
   endtask

   // Model: each core's words must leave in program order, each exactly once.
   task automatic score(input string tag, input int sh);
      int head[8];
      int total;
      int c;
      logic [15:0] v;
      total = 0;
      for (int i = 0; i < 8; i++) begin head[i] = 0; total += exp_n[i]; end
      check($sformatf("%s count", tag), obs_val.size(), total);
      for (int i = 0; i < obs_val.size(); i++) begin
         v = obs_val[i];
         c = int'((v >> sh) & 16'h7);
         if (head[c] < exp_n[c]) begin
            check($sformatf("%s core%0d word%0d", tag, c, head[c]), v, exp_w[c][head[c]]);
         end else begin
            check($sformatf("%s core%0d surplus", tag, c), head[c] + 1, exp_n[c]);
         end
         head[c]++;
      end
      for (int i = 0; i < 8; i++) check($sformatf("%s core%0d drained", tag, i), head[i], exp_n[i]);
   endtask

   task automatic all_write_id();
      clear_prog();
      for (int c = 0; c < 8; c++) begin
         prog[c][0] = ins(OP_LDID, 12'h000);
         prog[c][1] = ins(OP_ST, 12'h000);
         prog[c][2] = IO;
      end
   endtask

   initial begin
      int n_before, a, n;
      logic [15:0] v;

      // Reset held three cycles with idle cores.
      clear_prog();
      load_prog();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset en c%0d", i), output_enable, 1'b0);
         check($sformatf("reset val c%0d", i), output_val, 16'h0000);
      end
      reset = 1'b0;
      @(negedge clk);
      check("post-release en", output_enable, 1'b0);
      check("post-release val", output_val, 16'h0000);

      // Single writer: pulse two cycles after the store cycle.
      clear_prog();
      prog[5][0] = ins(OP_LDI, 12'h000);
      prog[5][1] = 16'h1234;
      prog[5][2] = ins(OP_ST, 12'h000);
      prog[5][3] = IO;
      start();
      run(25);
      check("single count", obs_val.size(), 1);
      if (obs_val.size() > 0) begin
         check("single val", obs_val[0], 16'h1234);
         check("single cycle", obs_cyc[0], rel + 3);
      end

      // All cores store their id in the same cycle.
      all_write_id();
      start();
      run(25);
      check("all8 count", obs_val.size(), 8);
      for (int i = 0; i < 8 && i < obs_val.size(); i++) begin
         check($sformatf("all8 val%0d", i), obs_val[i], i);
         check($sformatf("all8 cyc%0d", i), obs_cyc[i], rel + 3 + i);
      end

      // Core3 streams a,b,c while core4 competes with 0044.
      clear_prog();
      prog[3][0] = ins(OP_OUTI, 12'h00a);
      prog[3][1] = ins(OP_OUTI, 12'h00b);
      prog[3][2] = ins(OP_OUTI, 12'h00c);
      prog[4][0] = ins(OP_OUTI, 12'h044);
      start();
      run(25);
      check("mix count", obs_val.size(), 4);
      if (obs_val.size() == 4) begin
         check("mix w0", obs_val[0], 16'h000a);
         check("mix w1", obs_val[1], 16'h0044);
         check("mix w2", obs_val[2], 16'h000b);
         check("mix w3", obs_val[3], 16'h000c);
      end

      // Reset while the holding registers are draining.
      all_write_id();
      start();
      wait_pulses(3, 30, "drain timeout");
      #1 reset = 1'b1;
      #1;
      check("midreset en", output_enable, 1'b0);
      check("midreset val", output_val, 16'h0000);
      n_before = obs_val.size();
      clear_prog();
      load_prog();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      run(30);
      check("no leftovers", obs_val.size(), n_before);

      // Shared image: every core emits CORE_ID*0x100 + k, k=0..3.
      clear_prog();
      for (int c = 0; c < 8; c++) begin
         prog[c][0] = ins(OP_LDID, 12'h008);
         a = 1;
         for (int k = 0; k < 4; k++) begin
            if (k > 0) begin prog[c][a] = ins(OP_ADDI, 12'h001); a++; end
            prog[c][a] = ins(OP_ST, 12'h000);
            prog[c][a+1] = IO;
            a += 2;
            exp_w[c][k] = 16'((c * 256) + k);
         end
         exp_n[c] = 4;
      end
      start();
      run(2000);
      score("image", 8);

      // Randomised programs; bits [11:9] of every word name the issuing core.
      for (int r = 0; r < 3; r++) begin
         clear_prog();
         for (int c = 0; c < 8; c++) begin
            a = 0;
            n = $urandom_range(0, 6);
            for (int w = 0; w < n; w++) begin
               repeat ($urandom_range(0, 2)) begin prog[c][a] = ins(OP_NOP, 12'h000); a++; end
               v = {4'($urandom), 3'(c), 9'($urandom)};
               if ($urandom_range(0, 1) == 1) begin
                  v[15:12] = 4'h0;
                  prog[c][a] = ins(OP_OUTI, v[11:0]);
                  a++;
               end else begin
                  prog[c][a]   = ins(OP_LDI, 12'h000);
                  prog[c][a+1] = v;
                  prog[c][a+2] = ins(OP_ST, 12'h000);
                  prog[c][a+3] = IO;
                  a += 4;
               end
               exp_w[c][w] = v;
            end
            exp_n[c] = n;
         end
         start();
         run(300);
         score($sformatf("rand%0d", r), 9);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
